mult_div_unit: RTL and testbench



---
 rtl/mult_div_unit.sv | 141 ++++++++++++++
 tb/tb_mult_div_unit.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Iterative MIPS MULT/MULTU/DIV/DIVU into HI/LO, plus direct MTHI/MTLO loads.
// Latency DATA_WIDTH+1 cycles (1 for divide-by-zero); start is ignored while busy, no queueing.
// Divider built only when MULTDIV_DIV_EN is defined; otherwise divides complete in 1 cycle with no effect.
module mult_div_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  resetN,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  hiWrite,
  input  logic                  loWrite,
  input  logic [DATA_WIDTH-1:0] writeData,
  output logic                  busy,
  output logic                  done,
  output logic                  divByZero,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  state_t state;

  // acc[2W:W] is the running upper product / remainder, acc[W-1:0] the multiplier / quotient
  logic [2*W:0]   acc;
  logic [W-1:0]   opb;
  logic [CW-1:0]  count;
  logic           is_div;
  logic           neg_q;

  logic           sgn;
  logic [W-1:0]   a_mag, b_mag;
  logic [W:0]     mul_sum;
  logic [2*W-1:0] prod, prod_n;

  assign sgn     = ~op[0];
  assign a_mag   = (sgn && a[W-1]) ? -a : a;
  assign b_mag   = (sgn && b[W-1]) ? -b : b;
  assign mul_sum = acc[2*W:W] + {1'b0, opb};
  assign prod    = acc[2*W-1:0];
  assign prod_n  = -prod;

`ifdef MULTDIV_DIV_EN
  logic       neg_r;
  logic       dz;
  logic [W:0] shifted, diff;
  logic [W-1:0] quo, rem;

  assign shifted = {acc[2*W-1:W], acc[W-1]};
  assign diff    = shifted - {1'b0, opb};
  assign quo     = neg_q ? -acc[W-1:0] : acc[W-1:0];
  assign rem     = neg_r ? -acc[2*W-1:W] : acc[2*W-1:W];
`endif

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      divByZero <= 1'b0;
      hi        <= '0;
      lo        <= '0;
      acc       <= '0;
      opb       <= '0;
      count     <= '0;
      is_div    <= 1'b0;
      neg_q     <= 1'b0;
`ifdef MULTDIV_DIV_EN
      neg_r     <= 1'b0;
      dz        <= 1'b0;
`endif
    end else begin
      done      <= 1'b0;
      divByZero <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy   <= 1'b1;
            is_div <= op[1];
            neg_q  <= sgn & (a[W-1] ^ b[W-1]);
            acc    <= {{(W+1){1'b0}}, op[1] ? a_mag : b_mag};
            opb    <= op[1] ? b_mag : a_mag;
            count  <= CW'(W);
`ifdef MULTDIV_DIV_EN
            neg_r  <= sgn & a[W-1];
            dz     <= op[1] && (b == '0);
            if (op[1] && (b == '0)) begin
              // raw dividend is parked in acc so FIX can copy it to HI
              acc   <= {{(W+1){1'b0}}, a};
              state <= FIX;
            end else begin
              state <= CALC;
            end
`else
            state  <= op[1] ? FIX : CALC;
`endif
          end else begin
            if (hiWrite) hi <= writeData;
            if (loWrite) lo <= writeData;
          end
        end
        CALC: begin
          count <= count - CW'(1);
          if (count == CW'(1)) state <= FIX;
`ifdef MULTDIV_DIV_EN
          if (is_div)
            acc <= {diff[W] ? shifted : diff, acc[W-2:0], ~diff[W]};
          else
            acc <= {1'b0, acc[0] ? mul_sum : acc[2*W:W], acc[W-1:1]};
`else
          acc <= {1'b0, acc[0] ? mul_sum : acc[2*W:W], acc[W-1:1]};
`endif
        end
        FIX: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
`ifdef MULTDIV_DIV_EN
          divByZero <= dz;
          if (dz) begin
            hi <= acc[W-1:0];
            lo <= '1;
          end else if (is_div) begin
            hi <= rem;
            lo <= quo;
          end else begin
            {hi, lo} <= neg_q ? prod_n : prod;
          end
`else
          if (!is_div) {hi, lo} <= neg_q ? prod_n : prod;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: stimulus pushes expected HI/LO/divByZero/done-cycle, monitor pops on done.
module tb_mult_div_unit;
  logic        clock = 1'b0;
  logic        resetN = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0, b = '0;
  logic        hiWrite = 1'b0, loWrite = 1'b0;
  logic [31:0] writeData = '0;
  logic        busy, done, divByZero;
  logic [31:0] hi, lo;

  mult_div_unit #(.DATA_WIDTH(32)) dut (
    .clock(clock), .resetN(resetN), .start(start), .op(op), .a(a), .b(b),
    .hiWrite(hiWrite), .loWrite(loWrite), .writeData(writeData),
    .busy(busy), .done(done), .divByZero(divByZero), .hi(hi), .lo(lo)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          cyc;
  } exp_t;

  exp_t  sb[$];
  string nm_q[$];
  int    vectors = 0;
  int    miscompares = 0;
  logic [31:0] cur_hi = '0, cur_lo = '0;

  // monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clock) begin
    if (resetN && done) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL spurious_done at cycle %0d: hi=%h lo=%h dbz=%b, none expected", cyc, hi, lo, divByZero);
      end else begin
        exp_t  e;
        string n;
        e = sb.pop_front();
        n = nm_q.pop_front();
        if (hi !== e.hi || lo !== e.lo || divByZero !== e.dbz || cyc != e.cyc)
          begin
            miscompares++;
            $display("FAIL %s: got hi=%h lo=%h dbz=%b cycle=%0d, expected hi=%h lo=%h dbz=%b cycle=%0d",
                     n, hi, lo, divByZero, cyc, e.hi, e.lo, e.dbz, e.cyc);
          end
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // called at a negedge; returns at the negedge after the sampling edge
  task automatic issue(input string nm, input logic [1:0] o, input logic [31:0] aa, input logic [31:0] bb,
                       input logic [31:0] ehi, input logic [31:0] elo, input logic edbz, input int lat,
                       input bit push);
    exp_t e;
    start = 1'b1; op = o; a = aa; b = bb;
    @(negedge clock);
    start = 1'b0;
    e.hi = ehi; e.lo = elo; e.dbz = edbz; e.cyc = cyc + lat;
`ifndef MULTDIV_DIV_EN
    if (o[1]) begin
      e.hi = cur_hi; e.lo = cur_lo; e.dbz = 1'b0; e.cyc = cyc + 1;
    end
`endif
    if (push) begin
      sb.push_back(e);
      nm_q.push_back(nm);
      cur_hi = e.hi;
      cur_lo = e.lo;
    end
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    @(negedge clock);
    while (!done && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (!done) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: done not seen within 100 cycles, required 1", nm);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_dbz", 32'(divByZero), 32'd0);
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    @(negedge clock);
    resetN = 1'b1;
    @(negedge clock);

    // MTHI / MTLO
    hiWrite = 1'b1; writeData = 32'h0000_1234;
    @(negedge clock);
    hiWrite = 1'b0;
    check("mthi_hi", hi, 32'h0000_1234);
    check("mthi_lo", lo, 32'h0);
    loWrite = 1'b1; writeData = 32'h0000_5678;
    @(negedge clock);
    loWrite = 1'b0;
    check("mtlo_lo", lo, 32'h0000_5678);
    cur_hi = 32'h0000_1234; cur_lo = 32'h0000_5678;

    issue("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 33, 1);
    check("multu_busy", 32'(busy), 32'd1);
    check("multu_hi_held", hi, 32'h0000_1234);
    wait_done("multu_max");

    issue("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 33, 1);
    wait_done("mult_neg");
    // back-to-back start in the done cycle
    issue("div_neg", 2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33, 1);
    check("b2b_done_drop", 32'(done), 32'd0);
    wait_done("div_neg");

    @(negedge clock);
    issue("divu_by_zero", 2'b11, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, 1'b1, 1, 1);
    wait_done("divu_by_zero");
    @(negedge clock);
    issue("divu_after_dz", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 33, 1);
    wait_done("divu_after_dz");

    @(negedge clock);
    issue("div_overflow", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, 33, 1);
    wait_done("div_overflow");

    // start and MTHI while busy are ignored
    @(negedge clock);
    issue("multu_busy_ign", 2'b01, 32'd5, 32'd6, 32'h0, 32'd30, 1'b0, 33, 1);
    repeat (4) @(negedge clock);
    start = 1'b1; op = 2'b11; a = 32'd1; b = 32'd0;
    hiWrite = 1'b1; writeData = 32'hDEAD_BEEF;
    @(negedge clock);
    start = 1'b0; hiWrite = 1'b0;
    check("busy_held", 32'(busy), 32'd1);
    wait_done("multu_busy_ign");
    check("busy_hi_ign", hi, 32'h0);

    // start and MTLO in the same idle cycle: write dropped
    @(negedge clock);
    loWrite = 1'b1; writeData = 32'h0000_BEEF;
    issue("multu_lowrite", 2'b01, 32'd2, 32'd3, 32'h0, 32'd6, 1'b0, 33, 1);
    loWrite = 1'b0;
    check("lowrite_dropped", lo, 32'd30);
    wait_done("multu_lowrite");

    // asynchronous reset in the middle of a multiply
    @(negedge clock);
    issue("mult_aborted", 2'b00, 32'h11, 32'h22, 32'h0, 32'h0, 1'b0, 33, 0);
    repeat (9) @(negedge clock);
    resetN = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_hi", hi, 32'h0);
    check("arst_lo", lo, 32'h0);
    cur_hi = '0; cur_lo = '0;
    @(negedge clock);
    resetN = 1'b1;
    repeat (40) @(negedge clock);
    issue("mult_6x7", 2'b00, 32'd6, 32'd7, 32'h0, 32'd42, 1'b0, 33, 1);
    wait_done("mult_6x7");

    repeat (3) @(negedge clock);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
